// File: rtl/qracc_sram_seq_if.sv
// qracc_sram_seq_if: request/response bus between a master and the SRAM sequencer
interface qracc_sram_seq_if #(
  parameter int numRows = 128,
  parameter int numCols = 32
);
  logic rq_wr_i;
  logic rq_valid_i;
  logic rq_ready_o;
  logic [$clog2(numRows)-1:0] addr_i;
  logic [numCols-1:0] wr_data_i;
  logic rd_valid_o;
  logic [numCols-1:0] rd_data_o;
  modport master (
    output rq_wr_i, rq_valid_i, addr_i, wr_data_i,
    input rq_ready_o, rd_valid_o, rd_data_o
  );
  modport slave (
    input rq_wr_i, rq_valid_i, addr_i, wr_data_i,
    output rq_ready_o, rd_valid_o, rd_data_o
  );
endinterface

// File: rtl/qracc_sram_seq.sv
// qracc_sram_seq: precharge/write/sense sequencer for an analog SRAM macro; define SRAM_SEQ_WRITE_VERIFY_EN to add a write readback with wr_err_o
module qracc_sram_seq #(
  parameter int numRows = 128,
  parameter int numCols = 32,
  parameter int pchCycles = 2,
  parameter int wrCycles = 1
) (
  input  logic clk,
  input  logic rst,
  qracc_sram_seq_if.slave bus,
  output logic [numRows-1:0] WL,
  output logic PCH,
  output logic WRITE,
  output logic [numCols-1:0] WR_DATA,
  output logic [numCols-1:0] CSEL,
  output logic SAEN,
  input  logic [numCols-1:0] SA_OUT
`ifdef SRAM_SEQ_WRITE_VERIFY_EN
  ,
  output logic wr_err_o
`endif
);
  typedef enum logic [2:0] {IDLE, PRE, WR, WLON, SENSE} state_t;
  state_t state;
  int cnt;
  logic [$clog2(numRows)-1:0] addr_q;
  logic [numCols-1:0] data_q;
  logic wr_q;
  logic go_wr;
`ifdef SRAM_SEQ_WRITE_VERIFY_EN
  logic vfy;
  assign go_wr = wr_q && !vfy;
`else
  assign go_wr = wr_q;
`endif
  // Sequencer FSM; every macro-facing output is a register so the analog side never sees glitches
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= 0;
      addr_q <= '0;
      data_q <= '0;
      wr_q <= 1'b0;
      bus.rq_ready_o <= 1'b0;
      bus.rd_valid_o <= 1'b0;
      bus.rd_data_o <= '0;
      WL <= '0;
      PCH <= 1'b0;
      WRITE <= 1'b0;
      WR_DATA <= '0;
      CSEL <= '0;
      SAEN <= 1'b0;
`ifdef SRAM_SEQ_WRITE_VERIFY_EN
      vfy <= 1'b0;
      wr_err_o <= 1'b0;
`endif
    end else begin
      bus.rd_valid_o <= 1'b0;
`ifdef SRAM_SEQ_WRITE_VERIFY_EN
      wr_err_o <= 1'b0;
`endif
      case (state)
        IDLE:
          if (bus.rq_valid_i && bus.rq_ready_o) begin
            addr_q <= bus.addr_i;
            data_q <= bus.wr_data_i;
            wr_q <= bus.rq_wr_i;
            bus.rq_ready_o <= 1'b0;
            PCH <= 1'b1;
            cnt <= 1;
            state <= PRE;
          end else bus.rq_ready_o <= 1'b1;
        PRE:
          if (cnt < pchCycles) cnt <= cnt + 1;
          else begin
            PCH <= 1'b0;
            WL <= numRows'(1) << addr_q;
            cnt <= 1;
            if (go_wr) begin
              WRITE <= 1'b1;
              WR_DATA <= data_q;
              CSEL <= '1;
              state <= WR;
            end else state <= WLON;
          end
        WR:
          if (cnt < wrCycles) cnt <= cnt + 1;
          else begin
            WL <= '0;
            WRITE <= 1'b0;
            WR_DATA <= '0;
            CSEL <= '0;
`ifdef SRAM_SEQ_WRITE_VERIFY_EN
            vfy <= 1'b1;
            PCH <= 1'b1;
            cnt <= 1;
            state <= PRE;
`else
            bus.rq_ready_o <= 1'b1;
            state <= IDLE;
`endif
          end
        WLON: begin
          SAEN <= 1'b1;
          state <= SENSE;
        end
        SENSE: begin
          WL <= '0;
          SAEN <= 1'b0;
          bus.rq_ready_o <= 1'b1;
          state <= IDLE;
`ifdef SRAM_SEQ_WRITE_VERIFY_EN
          if (vfy) begin
            vfy <= 1'b0;
            wr_err_o <= SA_OUT != data_q;
          end else begin
            bus.rd_data_o <= SA_OUT;
            bus.rd_valid_o <= 1'b1;
          end
`else
          bus.rd_data_o <= SA_OUT;
          bus.rd_valid_o <= 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
endmodule
